// File: rtl/fpmul_sched.sv
// fpmul_sched: round-robin arbiter sharing one pipelined fpmul between two requesters,
// with a tag pipeline that routes each product back to its owner.
module fpmul_sched #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_c,
    input  logic        mul_omu,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_omu,
    output logic [3:0]  inflight,
    output logic        idle
);
    logic          rr_q, rr_d;
    logic [31:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_omu_q, rsp_omu_d;
    logic          rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [LAT:0]  tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic [3:0]    inflight_q, inflight_d;
    logic          both, acc, sel1, fire;

    always_comb begin
        both         = req0_valid && req1_valid;
        req0_ready   = req0_valid && (!req1_valid || !rr_q);
        req1_ready   = req1_valid && (!req0_valid || rr_q);
        acc          = req0_ready || req1_ready;
        sel1         = req1_ready;
        rr_d         = both ? ~rr_q : rr_q;
        mul_a_d      = !acc ? 32'h0 : sel1 ? req1_a : req0_a;
        mul_b_d      = !acc ? 32'h0 : sel1 ? req1_b : req0_b;
        // the oldest tag leaves the pipe at the same edge the product is captured
        fire         = tag_v_q[LAT];
        tag_v_d      = {tag_v_q[LAT-1:0], acc};
        tag_id_d     = {tag_id_q[LAT-1:0], sel1};
        rsp0_valid_d = fire && !tag_id_q[LAT];
        rsp1_valid_d = fire && tag_id_q[LAT];
        rsp_data_d   = fire ? mul_c : rsp_data_q;
        rsp_omu_d    = fire ? mul_omu : rsp_omu_q;
        inflight_d   = inflight_q + {3'b0, acc} - {3'b0, fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_data_q   <= '0;
            rsp_omu_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            inflight_q   <= '0;
        end else begin
            rr_q         <= rr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_omu_q    <= rsp_omu_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            inflight_q   <= inflight_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_omu    = rsp_omu_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign inflight   = inflight_q;
    assign idle       = (inflight_q == 4'd0);
endmodule

// File: tb/tb_fpmul_sched.sv
// tb_fpmul_sched: directed test of fpmul_sched (LAT=1) against a one-stage fpmul lookup model.
module tb_fpmul_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] mul_a, mul_b, rsp_data;
    logic [31:0] mul_c = '0;
    logic        mul_omu = 1'b0;
    logic        rsp0_valid, rsp1_valid, rsp_omu, idle;
    logic [3:0]  inflight;
    int          n_cmp = 0, n_err = 0;
    logic        exp_r0, exp_r1;

    fpmul_sched #(.LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_omu(mul_omu),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_omu(rsp_omu),
        .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // hand-computed single-precision products, {omu, product}
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40400000, 32'h40000000}: fmul = {1'b0, 32'h40C00000};
            {32'h3F800000, 32'h40A00000}: fmul = {1'b0, 32'h40A00000};
            {32'h40000000, 32'h40000000}: fmul = {1'b0, 32'h40800000};
            {32'h7F000000, 32'h7F000000}: fmul = {1'b1, 32'h7F800000};
            default:                      fmul = 33'h0;
        endcase
    endfunction

    always @(posedge clk) {mul_omu, mul_c} <= fmul(mul_a, mul_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mul_a", mul_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_v", {rsp0_valid, rsp1_valid, rsp_omu}, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_idle", idle, 1);
        rst_n = 1'b1;

        // both requesters valid for 8 cycles straight from reset
        req0_a = 32'h3F800000; req0_b = 32'h40A00000;
        req1_a = 32'h40000000; req1_b = 32'h40000000;
        for (int i = 0; i < 11; i++) begin
            req0_valid = (i < 8);
            req1_valid = (i < 8);
            #1;
            chk("rr_rdy0", req0_ready, (i < 8) && (i % 2 == 0));
            chk("rr_rdy1", req1_ready, (i < 8) && (i % 2 == 1));
            step();
            chk("rr_mul_a", mul_a, (i >= 8) ? 32'h0 : (i % 2 == 1) ? 32'h40000000 : 32'h3F800000);
            chk("rr_inflight", inflight, (i == 0) ? 1 : (i < 8) ? 2 : (i == 8) ? 1 : 0);
            exp_r0 = (i >= 2) && (i <= 9) && (i % 2 == 0);
            exp_r1 = (i >= 2) && (i <= 9) && (i % 2 == 1);
            chk("rr_rsp0", rsp0_valid, exp_r0);
            chk("rr_rsp1", rsp1_valid, exp_r1);
            if (exp_r0 || exp_r1) chk("rr_data", rsp_data, exp_r0 ? 32'h40A00000 : 32'h40800000);
        end

        // single request from requester 0: 3.0 * 2.0
        req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h40000000;
        #1;
        chk("s_rdy0", req0_ready, 1);
        chk("s_rdy1", req1_ready, 0);
        step();
        req0_valid = 1'b0;
        chk("s_mul_a", mul_a, 32'h40400000);
        chk("s_mul_b", mul_b, 32'h40000000);
        chk("s_inflight", inflight, 1);
        chk("s_idle_lo", idle, 0);
        step();
        chk("s_rsp0_early", rsp0_valid, 0);
        chk("s_mul_a_clr", mul_a, 0);
        chk("s_mul_b_clr", mul_b, 0);
        step();
        chk("s_rsp0", rsp0_valid, 1);
        chk("s_rsp1", rsp1_valid, 0);
        chk("s_data", rsp_data, 32'h40C00000);
        chk("s_omu", rsp_omu, 0);
        chk("s_idle_hi", idle, 1);
        step();
        chk("s_rsp0_pulse", rsp0_valid, 0);
        chk("s_data_hold", rsp_data, 32'h40C00000);

        // a lone accept must not move the rr pointer
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rr_hold_rdy0", req0_ready, 1);
        chk("rr_hold_rdy1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;

        // requester 1 overflow
        req1_valid = 1'b1; req1_a = 32'h7F000000; req1_b = 32'h7F000000;
        #1;
        chk("o_rdy1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        step();
        step();
        chk("o_rsp1", rsp1_valid, 1);
        chk("o_rsp0", rsp0_valid, 0);
        chk("o_omu", rsp_omu, 1);
        chk("o_data", rsp_data, 32'h7F800000);

        // reset with two operations in flight
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("r_inflight2", inflight, 2);
        rst_n = 1'b0;
        #1;
        chk("r_inflight0", inflight, 0);
        chk("r_idle", idle, 1);
        chk("r_mul_a", mul_a, 0);
        chk("r_data", rsp_data, 0);
        chk("r_omu", rsp_omu, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            chk("r_inflight", inflight, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fpmul_sched.md
FPMUL_SCHED -- requirements
Module: fpmul_sched

Interface
REQ-001 Parameter: LAT, default 1, fpmul pipeline latency in clock edges from operand change to valid mul_c (legal 1..8).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an operand pair.
REQ-005 req0_ready / req1_ready  output  1 each  pair accepted this edge (combinational grant).
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single operands.
REQ-007 mul_a, mul_b  output  32 each  registered operands to the shared fpmul.
REQ-008 mul_c  input  32  fpmul product.
REQ-009 mul_omu  input  1  fpmul overflow/underflow flag.
REQ-010 rsp0_valid / rsp1_valid  output  1 each  one-cycle result pulse to owning requester.
REQ-011 rsp_data  output  32  registered product, shared by both requesters.
REQ-012 rsp_omu  output  1  registered mul_omu aligned with rsp_data.
REQ-013 inflight  output  4  count of accepted operations not yet returned.
REQ-014 idle  output  1  high when inflight == 0.

Function
REQ-015 Accept = reqN_valid && reqN_ready; at most one accept per cycle.
REQ-016 Grant: only one valid -> that one is granted; both valid -> requester selected by rr pointer.
REQ-017 rr pointer flips to the other requester after each accept where both were valid; unchanged otherwise.
REQ-018 reqN_ready low when reqN_valid low; ready never depends on response state (no backpressure, throughput 1/cycle).
REQ-019 At an accept edge, mul_a/mul_b load the granted pair; with no accept they load 0x00000000.
REQ-020 Tag pipeline of LAT+1 stages carries {valid, owner id}; stage 0 loads at every edge.
REQ-021 Result sampled at edge E0+LAT+1 (E0 = accept edge): rsp_data <= mul_c, rsp_omu <= mul_omu, rspN_valid high for exactly one cycle for owner N.
REQ-022 Total latency accept-edge to rsp valid = LAT+1 cycles; order of responses = order of accepts.
REQ-023 rsp_data/rsp_omu hold last value when no response is valid; rsp0_valid and rsp1_valid never both high.
REQ-024 inflight +1 on accept, -1 on response, unchanged when both occur in the same edge; never exceeds LAT+1.
REQ-025 Back-to-back accepts every cycle produce back-to-back response pulses with no gaps or loss.

Reset
REQ-026 rst_n low asynchronously clears: mul_a, mul_b, rsp_data = 0; rsp_omu, rsp0_valid, rsp1_valid = 0; tag pipeline empty; inflight = 0; idle = 1; rr points to requester 0.
REQ-027 Reset mid-operation discards all in-flight operations; no response pulse for them after release.
REQ-028 First accept possible at first rising edge with rst_n high.

Verification
REQ-029 LAT=1, req0 only, a=0x40400000 b=0x40000000, fpmul model -> rsp0_valid pulse 2 cycles after accept, rsp_data=0x40C00000, rsp_omu=0, rsp1_valid stays 0.
REQ-030 Both valid continuously 8 cycles from reset -> accepts alternate 0,1,0,1..., responses alternate owners in same order, inflight saturates at LAT+1.
REQ-031 Model drives mul_omu=1 for req1 pair 0x7F000000*0x7F000000 -> rsp1_valid with rsp_omu=1.
REQ-032 Accept 2 ops, assert rst_n low 1 cycle before first response -> no rspN_valid after release, inflight=0, idle=1.
REQ-033 Single accept then no traffic -> idle falls after accept edge, returns to 1 at response edge; mul_a/mul_b return to 0.
